// File: rtl/soda_change_ctrl_pkg.sv
// rtl/soda_change_ctrl_pkg.sv - shared FSM states and coin denominations for the change controller
package soda_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    SEL,
    REQ,
    FIN
  } state_t;

  localparam int NICKEL  = 5;
  localparam int DIME    = 10;
  localparam int QUARTER = 25;

endpackage

// File: rtl/soda_change_ctrl_if.sv
// rtl/soda_change_ctrl_if.sv - vend-side and ejector-side signals of the change controller
// Optional refill port exists only with SODA_COIN_INV_EN defined.
interface soda_change_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] tot;
  logic [W-1:0] s;
  logic         eject_ack;
`ifdef SODA_COIN_INV_EN
  logic         refill;
`endif
  logic         ej_q;
  logic         ej_d;
  logic         ej_n;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] rem;

  modport master (
    output start, tot, s, eject_ack,
`ifdef SODA_COIN_INV_EN
    output refill,
`endif
    input  ej_q, ej_d, ej_n, busy, done, err, rem
  );

  modport slave (
    input  start, tot, s, eject_ack,
`ifdef SODA_COIN_INV_EN
    input  refill,
`endif
    output ej_q, ej_d, ej_n, busy, done, err, rem
  );
endinterface

// File: rtl/soda_change_ctrl_coin_sel.sv
// rtl/soda_change_ctrl_coin_sel.sv - greedy largest-usable-coin selection for the owed change
module soda_coin_sel
  import soda_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_rem,
  input  logic [2:0]   i_avail,   // {quarter, dime, nickel} still in stock
  output logic [2:0]   o_coin,    // one-hot {quarter, dime, nickel}, zero when nothing fits
  output logic [W-1:0] o_val
);

  always_comb begin
    o_coin = 3'b000;
    o_val  = '0;
    if (i_rem >= W'(QUARTER) && i_avail[2]) begin
      o_coin = 3'b100;
      o_val  = W'(QUARTER);
    end else if (i_rem >= W'(DIME) && i_avail[1]) begin
      o_coin = 3'b010;
      o_val  = W'(DIME);
    end else if (i_rem >= W'(NICKEL) && i_avail[0]) begin
      o_coin = 3'b001;
      o_val  = W'(NICKEL);
    end
  end

endmodule

// File: rtl/soda_change_ctrl.sv
// rtl/soda_change_ctrl.sv - returns change one coin at a time with per-coin ack timeout
// Define SODA_COIN_INV_EN for finite per-denomination coin inventory with refill.
module soda_change_ctrl
  import soda_pkg::*;
#(
  parameter int ACK_TMO = 16,
  parameter int W       = 8
) (
  input logic               clk,
  input logic               rst,
  soda_change_ctrl_if.slave bus
);

  localparam int CW = $clog2(ACK_TMO + 1);

  state_t         r_state;
  logic [W-1:0]   r_tot;
  logic [W-1:0]   r_s;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_val;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_ej;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic [2:0]     w_avail;
  logic [2:0]     w_coin;
  logic [W-1:0]   w_val;

`ifdef SODA_COIN_INV_EN
  logic [3:0] r_inv_q;
  logic [3:0] r_inv_d;
  logic [3:0] r_inv_n;

  assign w_avail = {r_inv_q != 4'd0, r_inv_d != 4'd0, r_inv_n != 4'd0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inv_q <= 4'd15;
      r_inv_d <= 4'd15;
      r_inv_n <= 4'd15;
    end else if (r_state == IDLE && bus.refill) begin
      r_inv_q <= 4'd15;
      r_inv_d <= 4'd15;
      r_inv_n <= 4'd15;
    end else if (r_state == REQ && bus.eject_ack) begin
      if (r_ej[2]) r_inv_q <= r_inv_q - 4'd1;
      if (r_ej[1]) r_inv_d <= r_inv_d - 4'd1;
      if (r_ej[0]) r_inv_n <= r_inv_n - 4'd1;
    end
  end
`else
  assign w_avail = 3'b111;
`endif

  soda_coin_sel #(.W(W)) u_coin_sel (
    .i_rem   (r_rem),
    .i_avail (w_avail),
    .o_coin  (w_coin),
    .o_val   (w_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tot   <= '0;
      r_s     <= '0;
      r_rem   <= '0;
      r_val   <= '0;
      r_cnt   <= '0;
      r_ej    <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_tot   <= bus.tot;
            r_s     <= bus.s;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_tot < r_s) begin
            r_err   <= 1'b1;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rem   <= r_tot - r_s;
            r_state <= SEL;
          end
        end
        SEL: begin
          if (w_coin != 3'b000) begin
            r_ej    <= w_coin;
            r_val   <= w_val;
            r_cnt   <= '0;
            r_state <= REQ;
          end else if (r_rem >= W'(NICKEL)) begin
            // only reachable when inventory ran dry: change still owed stays visible
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            // sub-nickel residue is forfeited, nothing more is owed
            r_rem   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FIN;
          end
        end
        REQ: begin
          if (bus.eject_ack) begin
            r_ej    <= 3'b000;
            r_rem   <= r_rem - r_val;
            r_state <= SEL;
          end else if (r_cnt == CW'(ACK_TMO - 1)) begin
            r_ej    <= 3'b000;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ej_q = r_ej[2];
  assign bus.ej_d = r_ej[1];
  assign bus.ej_n = r_ej[0];
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;
  assign bus.rem  = r_rem;

endmodule

// File: tb/tb_soda_change_ctrl.sv
// tb/tb_soda_change_ctrl.sv - randomized change-return bench against a greedy-change reference model
module tb_soda_change_ctrl;

  localparam int W       = 8;
  localparam int ACK_TMO = 16;
  localparam int BUDGET  = 600;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;

  soda_change_ctrl_if #(.W(W)) bus ();

  soda_change_ctrl #(.ACK_TMO(ACK_TMO), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one vend transaction; fail_idx names the coin whose ack never comes (-1: all acked).
  task automatic run_txn(input int tot, input int s, input int dly, input int fail_idx, input bit noise);
    int coins[$];
    int exp_q, exp_d, exp_n, exp_rem, paid, chg, r;
    bit exp_done, exp_err;
    logic [2:0] ej, prev_ej;
    int nq, nd, nn, run, last_run, viol, lat, idx;
    bit fin, got_done, got_err, got_busy;
    int got_rem;

    exp_q = 0; exp_d = 0; exp_n = 0; exp_rem = 0; exp_done = 0; exp_err = 0;
    if (tot < s) begin
      exp_err = 1;
    end else begin
      chg = tot - s;
      r   = chg;
      while (r >= 25) begin coins.push_back(25); r -= 25; end
      while (r >= 10) begin coins.push_back(10); r -= 10; end
      while (r >= 5)  begin coins.push_back(5);  r -= 5;  end
      paid = 0;
      for (int i = 0; i < coins.size(); i++) begin
        if (fail_idx >= 0 && i > fail_idx) break;
        if (coins[i] == 25) exp_q++;
        if (coins[i] == 10) exp_d++;
        if (coins[i] == 5)  exp_n++;
        if (i != fail_idx) paid += coins[i];
      end
      if (fail_idx >= 0 && fail_idx < coins.size()) begin
        exp_err = 1;
        exp_rem = chg - paid;
      end else begin
        exp_done = 1;
      end
    end

    @(negedge clk);
    bus.tot   = tot[W-1:0];
    bus.s     = s[W-1:0];
    bus.start = 1'b1;
    prev_ej = 3'b000;
    nq = 0; nd = 0; nn = 0; run = 0; last_run = 0; viol = 0;
    fin = 0; got_done = 0; got_err = 0; got_busy = 1; got_rem = -1; lat = -1;
    for (int t = 0; t < BUDGET && !fin; t++) begin
      @(negedge clk);
      ej = {bus.ej_q, bus.ej_d, bus.ej_n};
      if ($countones(ej) > 1) viol++;
      if (ej != 3'b000 && prev_ej != 3'b000 && ej != prev_ej) viol++;
      if (ej != 3'b000 && prev_ej == 3'b000) begin
        run = 1;
        if (ej[2]) nq++;
        if (ej[1]) nd++;
        if (ej[0]) nn++;
      end else if (ej != 3'b000) begin
        run++;
      end
      if (ej != 3'b000) last_run = run;
      prev_ej = ej;
      if (bus.done || bus.err) begin
        fin      = 1;
        lat      = t;
        got_done = bus.done;
        got_err  = bus.err;
        got_busy = bus.busy;
        got_rem  = int'(bus.rem);
        bus.start     = 1'b0;
        bus.eject_ack = 1'b0;
      end else begin
        // stray starts mid-ejection must be ignored
        bus.start = (ej != 3'b000) && ($urandom_range(0, 7) == 0);
        if (bus.start) bus.tot = W'($urandom_range(0, 255));
        idx = nq + nd + nn - 1;
        if (ej != 3'b000)
          bus.eject_ack = (idx != fail_idx) && (run == dly);
        else
          bus.eject_ack = noise && ($urandom_range(0, 1) == 1);
      end
    end
    bus.start     = 1'b0;
    bus.eject_ack = 1'b0;

    chk($sformatf("finished tot=%0d s=%0d", tot, s), 32'(fin), 32'd1);
    chk($sformatf("done tot=%0d s=%0d", tot, s), 32'(got_done), 32'(exp_done));
    chk($sformatf("err tot=%0d s=%0d", tot, s), 32'(got_err), 32'(exp_err));
    chk($sformatf("quarters tot=%0d s=%0d", tot, s), 32'(nq), 32'(exp_q));
    chk($sformatf("dimes tot=%0d s=%0d", tot, s), 32'(nd), 32'(exp_d));
    chk($sformatf("nickels tot=%0d s=%0d", tot, s), 32'(nn), 32'(exp_n));
    chk($sformatf("rem tot=%0d s=%0d", tot, s), 32'(got_rem), 32'(exp_rem));
    chk($sformatf("busy_end tot=%0d s=%0d", tot, s), 32'(got_busy), 32'd0);
    chk($sformatf("ej_protocol tot=%0d s=%0d", tot, s), 32'(viol), 32'd0);
    if (tot == s)
      chk($sformatf("zero_change_latency tot=%0d", tot), 32'(lat), 32'd2);
    if (exp_err && tot >= s)
      chk($sformatf("ack_timeout_width tot=%0d s=%0d", tot, s), 32'(last_run), 32'(ACK_TMO));
  endtask

  initial begin
    n_asserts     = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.tot       = '0;
    bus.s         = '0;
    bus.eject_ack = 1'b0;
`ifdef SODA_COIN_INV_EN
    bus.refill    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", {22'd0, bus.ej_q, bus.ej_d, bus.ej_n, bus.busy, bus.done, bus.err, 2'b00},
        32'd0);
    chk("reset_rem", 32'(bus.rem), 32'd0);
    rst = 1'b1;

    run_txn(165, 140, 2, -1, 0);
    run_txn(140, 140, 2, -1, 1);
    run_txn(100, 150, 2, -1, 1);
    run_txn(255, 5, 2, -1, 0);
    run_txn(250, 5, 1, -1, 1);
    run_txn(200, 160, 2, 0, 0);
    run_txn(144, 100, 3, 2, 1);
    run_txn(5, 0, 4, -1, 1);
    run_txn(4, 0, 1, -1, 1);

    // reset while a dime is being requested
    @(negedge clk);
    bus.tot   = 8'd160;
    bus.s     = 8'd140;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 20 && !bus.ej_d; t++) @(negedge clk);
    chk("ej_d_before_reset", 32'(bus.ej_d), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("reset_mid_ej", {23'd0, bus.ej_q, bus.ej_d, bus.ej_n, bus.busy, bus.done, bus.err, 3'b000},
        32'd0);
    chk("reset_mid_rem", 32'(bus.rem), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_txn(160, 140, 2, -1, 1);

    for (int k = 0; k < 25; k++) begin
      int tot, s, fidx;
      tot = $urandom_range(0, 255);
      s   = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0 && s > tot) begin
        int tmp;
        tmp = s; s = tot; tot = tmp;
      end
      fidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      run_txn(tot, s, $urandom_range(1, 4), fidx, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
